// File: rtl/alu_exec_pkg.sv
// Shared constants, select codes and FSM state type for the ALU execute unit.
package alu_exec_pkg;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_RSVD  = 2'b11;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;

  localparam logic [3:0] SEL_AND     = 4'b0000;
  localparam logic [3:0] SEL_OR      = 4'b0001;
  localparam logic [3:0] SEL_ADD     = 4'b0010;
  localparam logic [3:0] SEL_XOR     = 4'b0011;
  localparam logic [3:0] SEL_NOR     = 4'b0100;
  localparam logic [3:0] SEL_SUB     = 4'b0110;
  localparam logic [3:0] SEL_SLT     = 4'b0111;
  localparam logic [3:0] SEL_SLL     = 4'b1000;
  localparam logic [3:0] SEL_SRL     = 4'b1001;
  localparam logic [3:0] SEL_SLTU    = 4'b1011;
  localparam logic [3:0] SEL_MULTU   = 4'b1101;
  localparam logic [3:0] SEL_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU control decode: {alu_op, funct} -> {select, illegal, is_mul}.
// MULTU decodes as a multiply only when ALU_MULTU_EN is defined.
module alu_op_decode
  import alu_exec_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] select,
  output logic       illegal,
  output logic       is_mul
);

  always_comb begin
    select  = SEL_ILLEGAL;
    illegal = 1'b1;
    is_mul  = 1'b0;
    case (alu_op)
      ALU_OP_ADD: begin
        select  = SEL_ADD;
        illegal = 1'b0;
      end
      ALU_OP_SUB: begin
        select  = SEL_SUB;
        illegal = 1'b0;
      end
      ALU_OP_RTYPE: begin
        illegal = 1'b0;
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: select = SEL_ADD;
          FUNCT_SUB, FUNCT_SUBU: select = SEL_SUB;
          FUNCT_AND:             select = SEL_AND;
          FUNCT_OR:              select = SEL_OR;
          FUNCT_XOR:             select = SEL_XOR;
          FUNCT_NOR:             select = SEL_NOR;
          FUNCT_SLT:             select = SEL_SLT;
          FUNCT_SLTU:            select = SEL_SLTU;
          FUNCT_SLL:             select = SEL_SLL;
          FUNCT_SRL:             select = SEL_SRL;
`ifdef ALU_MULTU_EN
          FUNCT_MULTU: begin
            select = SEL_MULTU;
            is_mul = 1'b1;
          end
`else
          FUNCT_MULTU: begin
            select  = SEL_ILLEGAL;
            illegal = 1'b1;
          end
`endif
          default: begin
            select  = SEL_ILLEGAL;
            illegal = 1'b1;
          end
        endcase
      end
      ALU_OP_RSVD: begin
        select  = SEL_ILLEGAL;
        illegal = 1'b1;
      end
      default: begin
        select  = SEL_ILLEGAL;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake and registered outputs.
// Define ALU_MULTU_EN to build the iterative shift-add MULTU (WIDTH+1 edge latency).
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             illegal,
  output logic [SEL_W-1:0] select
);

  localparam int unsigned SH_W = $clog2(WIDTH);
`ifdef ALU_MULTU_EN
  localparam logic MULTU_EN = 1'b1;
`else
  localparam logic MULTU_EN = 1'b0;
`endif

  state_t           state;
  logic [3:0]       dec_select;
  logic             dec_illegal;
  logic             dec_is_mul;
  logic             accept;
  logic [SH_W-1:0]  sh_amt;
  logic [WIDTH-1:0] alu_res;

  alu_op_decode u_decode (
    .alu_op  (alu_op),
    .funct   (funct),
    .select  (dec_select),
    .illegal (dec_illegal),
    .is_mul  (dec_is_mul)
  );

  assign in_ready = rst_n && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  // Truncating (or zero-extending) shamt to log2(WIDTH) bits gives shamt mod WIDTH.
  assign sh_amt   = SH_W'(shamt);

  always_comb begin
    alu_res = '0;
    case (dec_select)
      SEL_AND:  alu_res = op_a & op_b;
      SEL_OR:   alu_res = op_a | op_b;
      SEL_XOR:  alu_res = op_a ^ op_b;
      SEL_NOR:  alu_res = ~(op_a | op_b);
      SEL_ADD:  alu_res = op_a + op_b;
      SEL_SUB:  alu_res = op_a - op_b;
      SEL_SLT:  alu_res[0] = $signed(op_a) < $signed(op_b);
      SEL_SLTU: alu_res[0] = op_a < op_b;
      SEL_SLL:  alu_res = op_b << sh_amt;
      SEL_SRL:  alu_res = op_b >> sh_amt;
      default:  alu_res = '0;
    endcase
  end

`ifdef ALU_MULTU_EN
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   result_hi_q;
  logic [SH_W-1:0]    count;

  assign acc_step  = acc + (mplier[0] ? mcand : '0);
  assign result_hi = result_hi_q;
`else
  assign result_hi = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      select    <= '0;
`ifdef ALU_MULTU_EN
      result_hi_q <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      count       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
`ifdef ALU_MULTU_EN
            if (dec_is_mul) begin
              state     <= MUL;
              out_valid <= 1'b0;
              acc       <= '0;
              mcand     <= {{WIDTH{1'b0}}, op_a};
              mplier    <= op_b;
              count     <= '0;
            end else
`endif
            begin
              out_valid <= 1'b1;
              result    <= alu_res;
              zero      <= (alu_res == '0);
              // A multiply request with no multiplier built is reported as illegal.
              illegal   <= dec_illegal | (dec_is_mul & ~MULTU_EN);
              select    <= dec_select;
`ifdef ALU_MULTU_EN
              result_hi_q <= '0;
`endif
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
`ifdef ALU_MULTU_EN
        MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == '1) begin
            state       <= HOLD;
            out_valid   <= 1'b1;
            result      <= acc_step[WIDTH-1:0];
            result_hi_q <= acc_step[2*WIDTH-1:WIDTH];
            zero        <= (acc_step[WIDTH-1:0] == '0);
            illegal     <= 1'b0;
            select      <= SEL_MULTU;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed steps plus random ops against a behavioural model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  alu_op = '0;
  logic [5:0]  funct = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        in_ready, out_valid, zero, illegal;
  logic [31:0] result, result_hi;
  logic [3:0]  select;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        ill;
    logic [3:0]  sel;
    logic        mul;
  } exp_t;

  alu_exec_unit #(.WIDTH(32), .SEL_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct     (funct),
    .shamt     (shamt),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .illegal   (illegal),
    .select    (select)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "time limit");
  end

  // Behavioural reference: MIPS-style semantics written as plain arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                 input logic [4:0] sh, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    e = '0;
    e.sel = 4'hF;
    if (op == 2'd0) begin e.res = a + b; e.sel = 4'd2; end
    else if (op == 2'd1) begin e.res = a - b; e.sel = 4'd6; end
    else if (op == 2'd3) e.ill = 1'b1;
    else begin
      case (f)
        6'h20, 6'h21: begin e.res = a + b; e.sel = 4'd2; end
        6'h22, 6'h23: begin e.res = a - b; e.sel = 4'd6; end
        6'h24: begin e.res = a & b; e.sel = 4'd0; end
        6'h25: begin e.res = a | b; e.sel = 4'd1; end
        6'h26: begin e.res = a ^ b; e.sel = 4'd3; end
        6'h27: begin e.res = ~(a | b); e.sel = 4'd4; end
        6'h2a: begin e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.sel = 4'd7; end
        6'h2b: begin e.res = (a < b) ? 32'd1 : 32'd0; e.sel = 4'd11; end
        6'h00: begin e.res = b << sh; e.sel = 4'd8; end
        6'h02: begin e.res = b >> sh; e.sel = 4'd9; end
`ifdef ALU_MULTU_EN
        6'h19: begin
          p = {32'd0, a} * {32'd0, b};
          e.res = p[31:0]; e.hi = p[63:32]; e.sel = 4'd13; e.mul = 1'b1;
        end
`endif
        default: e.ill = 1'b1;
      endcase
    end
    if (e.ill) begin e.res = '0; e.sel = 4'hF; end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, " result"}, 64'(result), 64'(e.res));
    chk({tag, " result_hi"}, 64'(result_hi), 64'(e.hi));
    chk({tag, " zero"}, 64'(zero), 64'(e.res == 32'd0));
    chk({tag, " illegal"}, 64'(illegal), 64'(e.ill));
    chk({tag, " select"}, 64'(select), 64'(e.sel));
  endtask

  // Called just after a clock edge; presents one single-cycle op and checks it one edge later.
  task automatic step(input string tag, input logic [1:0] op, input logic [5:0] f,
                      input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; alu_op = op; funct = f; shamt = sh; op_a = a; op_b = b;
    #1;
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check_out(tag, model(op, f, sh, a, b));
  endtask

  logic [5:0] ftab [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                            6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h19};

  initial begin
    exp_t e;
    logic [1:0] r_op;
    logic [5:0] r_f;
    int edges;
    logic seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst result", 64'(result), 64'd0);
    chk("rst result_hi", 64'(result_hi), 64'd0);
    chk("rst zero", 64'(zero), 64'd0);
    chk("rst illegal", 64'(illegal), 64'd0);
    chk("rst select", 64'(select), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;

    // Back-to-back stream
    step("add7_5", 2'b10, 6'h20, 5'd0, 32'd7, 32'd5);
    chk("add7_5 const", 64'(result), 64'd12);
    step("stream_sub", 2'b10, 6'h22, 5'd0, 32'd3, 32'd10);
    step("stream_and", 2'b10, 6'h24, 5'd0, 32'hF0F0_1234, 32'h0FF0_FF00);
    step("stream_or", 2'b10, 6'h25, 5'd0, 32'h1200_0000, 32'h0000_0034);
    step("beq", 2'b01, 6'h3f, 5'd0, 32'h1234, 32'h1234);
    chk("beq zero const", 64'(zero), 64'd1);
    step("slt", 2'b10, 6'h2a, 5'd0, 32'hFFFF_FFFF, 32'd1);
    chk("slt const", 64'(result), 64'd1);
    step("sltu", 2'b10, 6'h2b, 5'd0, 32'hFFFF_FFFF, 32'd1);
    chk("sltu const", 64'(result), 64'd0);
    step("sll31", 2'b10, 6'h00, 5'd31, 32'd0, 32'd1);
    chk("sll31 const", 64'(result), 64'h8000_0000);
    step("srl31", 2'b10, 6'h02, 5'd31, 32'd0, 32'h8000_0000);
    chk("srl31 const", 64'(result), 64'd1);
    step("bad_funct", 2'b10, 6'h3f, 5'd0, 32'd9, 32'd9);
    step("rsvd_op", 2'b11, 6'h20, 5'd0, 32'd9, 32'd9);
    chk("rsvd select const", 64'(select), 64'hF);
`ifndef ALU_MULTU_EN
    step("multu_off", 2'b10, 6'h19, 5'd0, 32'hFFFF_FFFF, 32'd2);
    chk("multu_off illegal const", 64'(illegal), 64'd1);
`endif

    // Random single-cycle ops
    for (int i = 0; i < 40; i++) begin
      r_op = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'($urandom_range(0, 3));
      r_f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ftab[$urandom_range(0, 12)];
`ifdef ALU_MULTU_EN
      if (r_op == 2'b10 && r_f == 6'h19) r_f = 6'h27;
`endif
      step("rand", r_op, r_f, 5'($urandom), $urandom, $urandom);
    end

    // Backpressure: outputs held and input stalled while out_ready = 0
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    e = model(2'b10, 6'h26, 5'd0, op_a, op_b);
    step("bp_xor", 2'b10, 6'h26, 5'd0, op_a, op_b);
    in_valid = 1'b1; funct = 6'h20; op_a = 32'd1; op_b = 32'd2;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp hold out_valid", 64'(out_valid), 64'd1);
      chk("bp hold result", 64'(result), 64'(e.res));
      chk("bp hold select", 64'(select), 64'(e.sel));
      chk("bp in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step("bp_release_nor", 2'b10, 6'h27, 5'd0, 32'h0F0F_0000, 32'h0000_00F0);

`ifdef ALU_MULTU_EN
    // Multiply latency and result
    in_valid = 1'b1; alu_op = 2'b10; funct = 6'h19; op_a = 32'hFFFF_FFFF; op_b = 32'd2;
    #1;
    chk("mul in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    chk("mul busy in_ready", 64'(in_ready), 64'd0);
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("mul latency", 64'(edges), 64'd33);
    check_out("mul", model(2'b10, 6'h19, 5'd0, 32'hFFFF_FFFF, 32'd2));
    chk("mul hi const", 64'(result_hi), 64'd1);
    chk("mul hold in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("mul drained out_valid", 64'(out_valid), 64'd0);
    chk("mul drained in_ready", 64'(in_ready), 64'd1);

    // Random multiply
    op_a = $urandom; op_b = $urandom;
    e = model(2'b10, 6'h19, 5'd0, op_a, op_b);
    in_valid = 1'b1; funct = 6'h19;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("rmul latency", 64'(edges), 64'd33);
    check_out("rmul", e);
    @(posedge clk); #1;

    // Reset during multiply aborts it
    in_valid = 1'b1; funct = 6'h19; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("mulrst in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mulrst no out_valid", 64'(seen), 64'd0);
`endif

    in_valid = 1'b0;
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
